// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the command sequencer.
//   CMD_W        default command word width
//   *_HI / *_LO  field bit positions: opcode [11:9], addr1 [8:6],
//                addr2 [5:3], addr3 [2:0]
//   opcode_e     legal opcodes (101 and 110 are not encoded here)
//   seq_state_e  sequencer FSM states
//   op_is_legal  classifies a 3-bit opcode as legal or illegal
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int CMD_W  = 12;
    localparam int OPC_W  = 3;

    localparam int OPC_HI = 11;
    localparam int OPC_LO = 9;
    localparam int A1_HI  = 8;
    localparam int A1_LO  = 6;
    localparam int A2_HI  = 5;
    localparam int A2_LO  = 3;
    localparam int A3_HI  = 2;
    localparam int A3_LO  = 0;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_NOT = 3'b100,
        OP_NOP = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_FETCH  = 2'b01,
        ST_ISSUE  = 2'b10,
        ST_FINISH = 2'b11
    } seq_state_e;

    // Only the six enumerated opcodes are issued; 101 and 110 are skipped.
    function automatic logic op_is_legal(input logic [OPC_W-1:0] op);
        logic legal;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_NOP: legal = 1'b1;
            default:                                       legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/cmd_store.sv
// -----------------------------------------------------------------------------
// cmd_store
// Program memory for the command sequencer: synchronous write, registered
// read with one cycle of latency. Contents have no reset so a program
// survives a sequencer reset.
//   clk    clock
//   we     write strobe
//   waddr  write slot
//   wdata  word to write
//   raddr  read slot (result appears after the next rising edge)
//   rdata  registered read data
// -----------------------------------------------------------------------------
module cmd_store #(
    parameter int DEPTH = 16,
    parameter int CMD_W = 12,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [CMD_W-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [CMD_W-1:0] rdata
);

    logic [CMD_W-1:0] mem_q [DEPTH];
    logic [CMD_W-1:0] rdata_q;

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Registered read; a write to the slot being read in the same edge is
    // forwarded so a start issued together with a load sees the new word.
    always_ff @(posedge clk) begin
        if (we && (waddr == raddr)) begin
            rdata_q <= wdata;
        end else begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/command_sequencer.sv
// -----------------------------------------------------------------------------
// command_sequencer
// Issues a stored program of command words to a downstream decoder over a
// valid/ready handshake, one command at most every two cycles.
//   clk, rst      clock, synchronous active-high reset
//   load_en/addr/data  program-slot write (honoured only while idle)
//   prog_len      number of slots to run, sampled on start, clamped to DEPTH
//   start         begin a run from slot 0 (honoured only while idle)
//   halt_req      early stop request
//   cmd_valid/cmd_ready/cmd  command handshake to the decoder
//   busy          high while a run is in progress
//   done          one-cycle pulse after a run ends
//   pc            slot currently presented or being evaluated
//   illegal_seen  sticky: an illegal opcode was skipped in this run
// -----------------------------------------------------------------------------
module command_sequencer #(
    parameter int DEPTH = 16,
    parameter int CMD_W = alu_pkg::CMD_W,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [AW-1:0]    load_addr,
    input  logic [CMD_W-1:0] load_data,
    input  logic [AW:0]      prog_len,
    input  logic             start,
    input  logic             halt_req,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [CMD_W-1:0] cmd,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    pc,
    output logic             illegal_seen
);

    import alu_pkg::*;

    localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PC_MAX    = AW'(DEPTH - 1);

    seq_state_e state_q, state_d;

    logic [AW:0]      len_q, len_d;
    logic [AW-1:0]    pc_q, pc_d;
    logic             halt_pend_q, halt_pend_d;
    logic             illegal_q, illegal_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             store_we_s;
    logic [CMD_W-1:0] rd_data_s;
    logic [AW:0]      len_clamp_s;
    logic [AW:0]      pc_cnt_next_s;
    logic [AW-1:0]    pc_inc_s;
    logic             last_s;
    logic [OPC_W-1:0] fetch_op_s;
    logic             fetch_legal_s;
    logic             handshake_s;

    assign store_we_s    = load_en && (state_q == ST_IDLE);
    assign len_clamp_s   = (prog_len > DEPTH_CNT) ? DEPTH_CNT : prog_len;
    // Slot count after the current one, one bit wider so a full-depth run
    // can be recognised without pc wrapping.
    assign pc_cnt_next_s = {1'b0, pc_q} + {{AW{1'b0}}, 1'b1};
    assign last_s        = (pc_cnt_next_s == len_q);
    assign pc_inc_s      = (pc_q == PC_MAX) ? pc_q : (pc_q + AW'(1));
    assign fetch_op_s    = rd_data_s[CMD_W-1 -: OPC_W];
    assign fetch_legal_s = op_is_legal(fetch_op_s);
    assign handshake_s   = (state_q == ST_ISSUE) && cmd_valid_q && cmd_ready;

    // The read address follows the next pc, so the word for a slot is
    // already in the read register during the FETCH cycle that evaluates it.
    cmd_store #(
        .DEPTH (DEPTH),
        .CMD_W (CMD_W)
    ) u_store (
        .clk   (clk),
        .we    (store_we_s),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (pc_d),
        .rdata (rd_data_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (len_clamp_s == {(AW+1){1'b0}}) ? ST_FINISH : ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (halt_req) begin
                    state_d = ST_FINISH;
                end else if (fetch_legal_s) begin
                    state_d = ST_ISSUE;
                end else if (last_s) begin
                    state_d = ST_FINISH;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_ISSUE: begin
                // A halt seen while waiting is held until the handshake.
                if (handshake_s) begin
                    state_d = (last_s || halt_pend_q || halt_req) ? ST_FINISH : ST_FETCH;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output and datapath next values.
    always_comb begin
        pc_d        = pc_q;
        len_d       = len_q;
        illegal_d   = illegal_q;
        halt_pend_d = halt_pend_q;
        cmd_d       = cmd_q;
        cmd_valid_d = (state_d == ST_ISSUE);
        busy_d      = (state_d != ST_IDLE);
        // done is registered off the FINISH state, so it follows it by a cycle.
        done_d      = (state_q == ST_FINISH);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d       = len_clamp_s;
                    pc_d        = {AW{1'b0}};
                    illegal_d   = 1'b0;
                    halt_pend_d = 1'b0;
                end else begin
                    len_d = len_q;
                end
            end
            ST_FETCH: begin
                if (halt_req) begin
                    pc_d = pc_q;
                end else if (fetch_legal_s) begin
                    cmd_d = rd_data_s;
                end else begin
                    illegal_d = 1'b1;
                    pc_d      = pc_inc_s;
                end
            end
            ST_ISSUE: begin
                if (halt_req) begin
                    halt_pend_d = 1'b1;
                end else begin
                    halt_pend_d = halt_pend_q;
                end
                if (handshake_s) begin
                    pc_d = pc_inc_s;
                end else begin
                    pc_d = pc_q;
                end
            end
            ST_FINISH: begin
                halt_pend_d = 1'b0;
            end
            default: begin
                pc_d = pc_q;
            end
        endcase
    end

    // Output and datapath registers; program memory is not touched by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q       <= {(AW+1){1'b0}};
            pc_q        <= {AW{1'b0}};
            halt_pend_q <= 1'b0;
            illegal_q   <= 1'b0;
            cmd_q       <= {CMD_W{1'b0}};
            cmd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            len_q       <= len_d;
            pc_q        <= pc_d;
            halt_pend_q <= halt_pend_d;
            illegal_q   <= illegal_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign cmd_valid    = cmd_valid_q;
    assign cmd          = cmd_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pc           = pc_q;
    assign illegal_seen = illegal_q;

endmodule

// File: doc/command_sequencer.md
COMMAND_SEQUENCER -- requirements
Module: command_sequencer

Interface
REQ-001 Parameter DEPTH, default 16, SHALL set the number of program slots (power of two, 2..256).
REQ-002 Parameter CMD_W, default 12, SHALL set the command width: opcode [11:9], addr1 [8:6], addr2 [5:3], addr3 [2:0].
REQ-003 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 load_en  input  1  SHALL be the program-slot write strobe.
REQ-006 load_addr  input  log2(DEPTH)  SHALL be the program slot to write.
REQ-007 load_data  input  CMD_W  SHALL be the command word to store.
REQ-008 prog_len  input  log2(DEPTH)+1  SHALL be the number of slots to issue; sampled on start.
REQ-009 start  input  1  SHALL be a one-cycle request to begin issuing from slot 0.
REQ-010 halt_req  input  1  SHALL request an early stop.
REQ-011 cmd_valid  output  1  SHALL mark cmd as valid.
REQ-012 cmd_ready  input  1  SHALL be the downstream decoder's acceptance.
REQ-013 cmd  output  CMD_W  SHALL be the issued command word.
REQ-014 busy  output  1  SHALL be high while not in IDLE.
REQ-015 done  output  1  SHALL pulse for one cycle when a run ends.
REQ-016 pc  output  log2(DEPTH)  SHALL show the slot currently presented or being evaluated.
REQ-017 illegal_seen  output  1  SHALL be a sticky flag for a skipped illegal opcode.

Function
REQ-018 FSM states SHALL be IDLE, FETCH, ISSUE, FINISH.
REQ-019 In IDLE, load_en SHALL write load_data to slot load_addr in the same edge; in any other state, load_en SHALL be ignored.
REQ-020 In IDLE, start SHALL latch prog_len, clear pc and illegal_seen, and go to FINISH if prog_len==0, else to FETCH.
REQ-021 start while not in IDLE SHALL be ignored.
REQ-022 FETCH SHALL read slot pc (1-cycle latency) into the cmd register.
REQ-023 Opcodes 000,001,010,011,100,111 SHALL be legal; for legal opcodes, FETCH SHALL go to ISSUE with cmd_valid=1 on the next cycle.
REQ-024 For opcode 101 or 110, FETCH SHALL set illegal_seen, not assert cmd_valid, and advance pc as if accepted.
REQ-025 In ISSUE, cmd and cmd_valid SHALL stay stable until the cycle in which cmd_valid and cmd_ready are both high.
REQ-026 On handshake, cmd_valid SHALL drop the next cycle; pc SHALL increment, then go to FETCH, or to FINISH if the incremented count equals the latched length.
REQ-027 Issue throughput SHALL be one command per 2 cycles maximum: FETCH, then ISSUE.
REQ-028 halt_req SHALL be sampled every cycle in FETCH/ISSUE; a pending ISSUE SHALL complete its handshake first, then go to FINISH; halt_req in FETCH SHALL go directly to FINISH.
REQ-029 FINISH SHALL assert done for exactly one cycle and return to IDLE.
REQ-030 prog_len > DEPTH SHALL be clamped to DEPTH; pc SHALL never wrap within a run.
REQ-031 Simultaneous start and load_en in IDLE: the write SHALL take effect and the run SHALL see the new word.
REQ-032 All outputs SHALL be registered.

Reset
REQ-033 On rst, the state SHALL be IDLE, and cmd_valid, done, busy, illegal_seen, pc and cmd SHALL all be 0; program memory contents SHALL be preserved.
REQ-034 rst during ISSUE SHALL drop cmd_valid on the next edge without completing the handshake.

Structure
REQ-035 Package alu_pkg SHALL hold CMD_W, the field bit positions, and the opcode enum: ADD=000, SUB=001, AND=010, OR=011, NOT=100, NOP=111.
REQ-036 Program storage SHALL be one sub-module, cmd_store: synchronous write, 1-cycle registered read.

Verification
REQ-037 Load slots 0..2 = 0x048, 0x253, 0x4C0; prog_len=3; cmd_ready=1 -> cmd 0x048, 0x253, 0x4C0 issued 2 cycles apart; done pulses once; busy then falls.
REQ-038 cmd_ready held low 5 cycles on the first command -> cmd_valid=1 and cmd=0x048 stable all 5 cycles; no pc advance.
REQ-039 Slot 1 = 0xA00 (opcode 101) with prog_len=3 -> only slots 0 and 2 issued; illegal_seen=1 at done.
REQ-040 prog_len=0 -> done pulses 2 cycles after start; cmd_valid never asserted.
REQ-041 halt_req asserted during ISSUE of slot 1 of 4 -> slot 1 handshake completes, slots 2–3 not issued, done pulses.
REQ-042 rst during ISSUE, then start -> cmd_valid low after reset; the rerun reissues slot 0 with unchanged memory contents.
